// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: receives a length-prefixed, XOR-checksummed
// byte frame, writes big-endian words to the imem write port and holds the core in reset.
module imem_loader #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic          rx_valid,
    input  logic [7:0]    rx_data,
    output logic          rx_ready,
    output logic          imem_we,
    output logic [AW-1:0] imem_waddr,
    output logic [31:0]   imem_wdata,
    output logic          cpu_reset,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam int LW = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_CHECK,
        S_DONE,
        S_ERR
    } state_t;

    state_t        state;
    logic [LW-1:0] len;
    logic [AW-1:0] word_idx;
    logic [1:0]    byte_cnt;
    logic [23:0]   wreg;
    logic [7:0]    acc;

    logic take;
    logic len_bad;
    logic last_word;

    assign take      = rx_valid && rx_ready;
    assign len_bad   = (rx_data == 8'd0) || (int'(rx_data) > DEPTH);
    assign last_word = (int'(word_idx) == int'(len) - 1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            len        <= '0;
            word_idx   <= '0;
            byte_cnt   <= '0;
            wreg       <= '0;
            acc        <= '0;
            rx_ready   <= 1'b0;
            imem_we    <= 1'b0;
            imem_waddr <= '0;
            imem_wdata <= '0;
            cpu_reset  <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state     <= S_LEN;
                        done      <= 1'b0;
                        err       <= 1'b0;
                        busy      <= 1'b1;
                        cpu_reset <= 1'b1;
                        rx_ready  <= 1'b1;
                        word_idx  <= '0;
                        byte_cnt  <= '0;
                        acc       <= '0;
                    end
                end
                S_LEN: begin
                    if (take) begin
                        if (len_bad) begin
                            state    <= S_ERR;
                            err      <= 1'b1;
                            busy     <= 1'b0;
                            rx_ready <= 1'b0;
                        end else begin
                            len   <= LW'(rx_data);
                            state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (take) begin
                        wreg     <= {wreg[15:0], rx_data};
                        acc      <= acc ^ rx_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        // The fourth byte completes the word directly from the shift register.
                        if (byte_cnt == 2'd3) begin
                            imem_we    <= 1'b1;
                            imem_waddr <= word_idx;
                            imem_wdata <= {wreg, rx_data};
                            word_idx   <= word_idx + 1'b1;
                            if (last_word) begin
                                state <= S_CHECK;
                            end
                        end
                    end
                end
                S_CHECK: begin
                    if (take) begin
                        rx_ready <= 1'b0;
                        busy     <= 1'b0;
                        if (rx_data == acc) begin
                            state     <= S_DONE;
                            done      <= 1'b1;
                            cpu_reset <= 1'b0;
                        end else begin
                            state <= S_ERR;
                            err   <= 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboarded bench for imem_loader: a frame-level model predicts word writes and
// final status; a negedge monitor compares each imem write against the queue.
module tb_imem_loader;

    localparam int DEPTH = 64;
    localparam int AW    = 6;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          rx_ready;
    logic          imem_we;
    logic [AW-1:0] imem_waddr;
    logic [31:0]   imem_wdata;
    logic          cpu_reset;
    logic          busy;
    logic          done;
    logic          err;

    always #5 clk = ~clk;

    imem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    int         n_cmp = 0;
    int         n_bad = 0;
    wr_t        exp_q[$];
    logic [7:0] frame[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every write pulse must match the oldest predicted write.
    always @(negedge clk) begin
        wr_t e;
        if (reset_n === 1'b1 && imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: got addr %0d data %h expected none", imem_waddr, imem_wdata);
            end else begin
                e = exp_q.pop_front();
                check("write_addr", 32'(imem_waddr), 32'(e.addr));
                check("write_data", imem_wdata, e.data);
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rx_ready"},  32'(rx_ready),   32'd0);
        check({tag, "_imem_we"},   32'(imem_we),    32'd0);
        check({tag, "_waddr"},     32'(imem_waddr), 32'd0);
        check({tag, "_wdata"},     imem_wdata,      32'd0);
        check({tag, "_cpu_reset"}, 32'(cpu_reset),  32'd1);
        check({tag, "_busy"},      32'(busy),       32'd0);
        check({tag, "_done"},      32'(done),       32'd0);
        check({tag, "_err"},       32'(err),        32'd0);
    endtask

    // Called at a negedge; leaves the bench at a negedge one cycle after the transfer.
    task automatic send_byte(input logic [7:0] b, input bit push, input wr_t w, input bit with_start);
        int k = 0;
        while (rx_ready !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (k >= 100) begin
            check("rx_ready_timeout", 32'(rx_ready), 32'd1);
            return;
        end
        rx_valid = 1'b1;
        rx_data  = b;
        if (with_start) start = 1'b1;
        if (push) exp_q.push_back(w);
        @(negedge clk);
        rx_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_busy",      32'(busy),      32'd1);
        check("start_rx_ready",  32'(rx_ready),  32'd1);
        check("start_cpu_reset", 32'(cpu_reset), 32'd1);
        check("start_done",      32'(done),      32'd0);
        check("start_err",       32'(err),       32'd0);
    endtask

    function automatic bit len_ok(input int n);
        return n >= 1 && n <= DEPTH;
    endfunction

    // Sends frame[], predicting one write per completed 4-byte group.
    task automatic send_frame(input int maxgap, input int start_at, input int count);
        int  n = int'(frame[0]);
        int  total;
        wr_t w;
        bit  push;
        total = len_ok(n) ? frame.size() : 1;
        if (count >= 0) total = count;
        for (int i = 0; i < total; i++) begin
            repeat ($urandom_range(maxgap, 0)) @(negedge clk);
            push = len_ok(n) && i >= 4 && i <= 4 * n && (i % 4 == 0);
            w.addr = AW'(i / 4 - 1);
            if (i >= 3) w.data = {frame[i-3], frame[i-2], frame[i-1], frame[i]};
            else        w.data = '0;
            send_byte(frame[i], push, w, i == start_at);
        end
    endtask

    task automatic check_final(input string tag);
        int         n = int'(frame[0]);
        logic [7:0] x = '0;
        bit         ok = 1'b0;
        if (len_ok(n)) begin
            for (int i = 1; i <= 4 * n; i++) x ^= frame[i];
            ok = (frame[4 * n + 1] == x);
        end
        check({tag, "_done"},      32'(done),      32'(ok));
        check({tag, "_err"},       32'(err),       32'(!ok));
        check({tag, "_busy"},      32'(busy),      32'd0);
        check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'(!ok));
        check({tag, "_rx_ready"},  32'(rx_ready),  32'd0);
        check({tag, "_pending"},   32'(exp_q.size()), 32'd0);
    endtask

    function automatic void build(input int n, input bit bad);
        logic [7:0] x = '0;
        logic [7:0] b;
        frame.delete();
        frame.push_back(8'(n));
        if (len_ok(n)) begin
            for (int i = 0; i < 4 * n; i++) begin
                b = 8'($urandom);
                frame.push_back(b);
                x ^= b;
            end
            frame.push_back(bad ? (x ^ 8'($urandom_range(255, 1))) : x);
        end
    endfunction

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n  = 1'b0;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("in_reset");
        reset_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("idle");

        // Directed good load
        do_start();
        frame = '{8'h02, 8'h20, 8'h02, 8'h00, 8'h05, 8'h20, 8'h03, 8'h00, 8'h0C, 8'h08};
        send_frame(0, -1, -1);
        check_final("good");
        check("good_done_fixed", 32'(done), 32'd1);

        // start while DONE reopens the load and reasserts core reset
        do_start();
        build(3, 1'b0);
        send_frame(0, -1, -1);
        check_final("after_done_restart");

        // Bad checksum: both writes still happen
        do_start();
        frame = '{8'h02, 8'h20, 8'h02, 8'h00, 8'h05, 8'h20, 8'h03, 8'h00, 8'h0C, 8'h09};
        send_frame(0, -1, -1);
        check_final("bad_cks");
        check("bad_cks_err_fixed", 32'(err), 32'd1);

        // Length limits
        do_start();
        frame = '{8'h00};
        send_frame(0, -1, -1);
        check_final("len0");
        do_start();
        frame = '{8'h41};
        send_frame(0, -1, -1);
        check_final("len65");
        do_start();
        build(64, 1'b0);
        send_frame(0, -1, -1);
        check_final("len64");

        // Backpressure
        do_start();
        frame = '{8'h02, 8'h20, 8'h02, 8'h00, 8'h05, 8'h20, 8'h03, 8'h00, 8'h0C, 8'h08};
        send_frame(5, -1, -1);
        check_final("bubbles");

        // Reset after 6 data bytes, then a clean reload
        do_start();
        send_frame(0, -1, 7);
        #2 reset_n = 1'b0;
        #1 check_reset_outputs("mid_reset");
        check("mid_reset_pending", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        do_start();
        send_frame(2, -1, -1);
        check_final("after_reset");

        // start pulsed during DATA is ignored
        do_start();
        build(4, 1'b0);
        send_frame(1, 6, -1);
        check_final("start_in_data");

        // Randomized frames
        for (int t = 0; t < 20; t++) begin
            int r = int'($urandom_range(9, 0));
            int n;
            if (r == 0)      n = 0;
            else if (r == 1) n = 65 + int'($urandom_range(190, 0));
            else             n = int'($urandom_range(8, 1));
            do_start();
            build(n, $urandom_range(3, 0) == 0);
            send_frame(int'($urandom_range(3, 0)), -1, -1);
            check_final("random");
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
